// File: rtl/mandel_pkg.sv
// Shared constants and FSM state type for the Mandelbrot pixel engine.
// Complex components are signed Q4.28 fixed point.
package mandel_pkg;

    localparam int unsigned Q_LEN         = 32;
    localparam int unsigned FRAC_LEN      = 28;
    localparam int unsigned INT_LEN       = Q_LEN - FRAC_LEN;
    localparam int unsigned PRE_MUL_SHIFT = 14;

    // |z|^2 escape bound of 4.0 in Q4.28
    localparam logic [Q_LEN-1:0] MANDEL_BOUND = Q_LEN'(4) << FRAC_LEN;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

endpackage

// File: rtl/mandel_step.sv
// Combinational z^2 + c step with escape detection, all arithmetic modulo 2^Q_LEN.
// Operands are pre-shifted so each product lands back in Q4.28 after truncation.
module mandel_step
    import mandel_pkg::*;
(
    input  logic [Q_LEN-1:0] z_real,
    input  logic [Q_LEN-1:0] z_imag,
    input  logic [Q_LEN-1:0] c_real,
    input  logic [Q_LEN-1:0] c_imag,
    output logic [Q_LEN-1:0] next_z_real,
    output logic [Q_LEN-1:0] next_z_imag,
    output logic             finished
);

    logic signed [Q_LEN-1:0] op_r;
    logic signed [Q_LEN-1:0] op_i;
    logic        [Q_LEN-1:0] rr;
    logic        [Q_LEN-1:0] ii;
    logic        [Q_LEN-1:0] ri;
    logic        [Q_LEN-1:0] mag_sq;

    always_comb begin
        op_r = $signed(z_real) >>> PRE_MUL_SHIFT;
        op_i = $signed(z_imag) >>> PRE_MUL_SHIFT;
        // Only the low Q_LEN bits of each product are kept, so signedness of the multiply is irrelevant
        rr   = Q_LEN'(op_r * op_r);
        ii   = Q_LEN'(op_i * op_i);
        ri   = Q_LEN'(op_r * op_i);

        next_z_real = rr - ii + c_real;
        next_z_imag = (ri << 1) + c_imag;

        mag_sq   = rr + ii;
        finished = mag_sq > MANDEL_BOUND;
    end

endmodule

// File: rtl/mandelbrot_pixel_engine.sv
// Per-pixel Mandelbrot iteration engine: accepts one job, iterates z^2+c one step
// per clock until escape or the iteration limit, then returns the count.
module mandelbrot_pixel_engine
    import mandel_pkg::*;
#(
    parameter int unsigned ITER_W = 16,
    parameter int unsigned ID_W   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [Q_LEN-1:0]  in_c_real,
    input  logic [Q_LEN-1:0]  in_c_imag,
    input  logic [ID_W-1:0]   in_id,
    input  logic [ITER_W-1:0] in_max_iter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_id,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped,
    output logic              busy
);

    state_t              state_q,       state_d;
    logic [Q_LEN-1:0]    c_real_q,      c_real_d;
    logic [Q_LEN-1:0]    c_imag_q,      c_imag_d;
    logic [Q_LEN-1:0]    z_real_q,      z_real_d;
    logic [Q_LEN-1:0]    z_imag_q,      z_imag_d;
    logic [ITER_W-1:0]   count_q,       count_d;
    logic [ITER_W-1:0]   max_iter_q,    max_iter_d;
    logic [ID_W-1:0]     id_q,          id_d;
    logic                in_ready_q,    in_ready_d;
    logic                out_valid_q,   out_valid_d;
    logic                busy_q,        busy_d;
    logic [ID_W-1:0]     out_id_q,      out_id_d;
    logic [ITER_W-1:0]   out_iter_q,    out_iter_d;
    logic                out_escaped_q, out_escaped_d;

    logic [Q_LEN-1:0]    next_z_real;
    logic [Q_LEN-1:0]    next_z_imag;
    logic                finished;
    logic [ITER_W-1:0]   count_inc;

    mandel_step u_step (
        .z_real      (z_real_q),
        .z_imag      (z_imag_q),
        .c_real      (c_real_q),
        .c_imag      (c_imag_q),
        .next_z_real (next_z_real),
        .next_z_imag (next_z_imag),
        .finished    (finished)
    );

    always_comb begin
        state_d       = state_q;
        c_real_d      = c_real_q;
        c_imag_d      = c_imag_q;
        z_real_d      = z_real_q;
        z_imag_d      = z_imag_q;
        count_d       = count_q;
        max_iter_d    = max_iter_q;
        id_d          = id_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        busy_d        = busy_q;
        out_id_d      = out_id_q;
        out_iter_d    = out_iter_q;
        out_escaped_d = out_escaped_q;
        count_inc     = count_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    c_real_d   = in_c_real;
                    c_imag_d   = in_c_imag;
                    id_d       = in_id;
                    max_iter_d = in_max_iter;
                    z_real_d   = '0;
                    z_imag_d   = '0;
                    count_d    = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    if (in_max_iter == '0) begin
                        state_d       = DONE;
                        out_valid_d   = 1'b1;
                        out_id_d      = in_id;
                        out_iter_d    = '0;
                        out_escaped_d = 1'b0;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                if (finished) begin
                    state_d       = DONE;
                    out_valid_d   = 1'b1;
                    out_id_d      = id_q;
                    out_iter_d    = count_q;
                    out_escaped_d = 1'b1;
                end else begin
                    z_real_d = next_z_real;
                    z_imag_d = next_z_imag;
                    count_d  = count_inc;
                    if (count_inc == max_iter_q) begin
                        state_d       = DONE;
                        out_valid_d   = 1'b1;
                        out_id_d      = id_q;
                        out_iter_d    = max_iter_q;
                        out_escaped_d = 1'b0;
                    end
                end
            end
            DONE: begin
                // in_ready rises only after the result handshake, so no same-cycle accept
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            c_real_q      <= '0;
            c_imag_q      <= '0;
            z_real_q      <= '0;
            z_imag_q      <= '0;
            count_q       <= '0;
            max_iter_q    <= '0;
            id_q          <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            out_id_q      <= '0;
            out_iter_q    <= '0;
            out_escaped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            c_real_q      <= c_real_d;
            c_imag_q      <= c_imag_d;
            z_real_q      <= z_real_d;
            z_imag_q      <= z_imag_d;
            count_q       <= count_d;
            max_iter_q    <= max_iter_d;
            id_q          <= id_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            out_id_q      <= out_id_d;
            out_iter_q    <= out_iter_d;
            out_escaped_q <= out_escaped_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign out_id      = out_id_q;
    assign out_iter    = out_iter_q;
    assign out_escaped = out_escaped_q;

endmodule

// File: tb/tb_mandelbrot_pixel_engine.sv
// Directed bench for mandelbrot_pixel_engine: hand-computed iteration counts,
// latencies, backpressure hold and mid-job reset.
module tb_mandelbrot_pixel_engine;

    localparam int unsigned ITER_W = 16;
    localparam int unsigned ID_W   = 20;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_c_real;
    logic [31:0]       in_c_imag;
    logic [ID_W-1:0]   in_id;
    logic [ITER_W-1:0] in_max_iter;
    logic              out_valid;
    logic              out_ready;
    logic [ID_W-1:0]   out_id;
    logic [ITER_W-1:0] out_iter;
    logic              out_escaped;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    mandelbrot_pixel_engine #(
        .ITER_W (ITER_W),
        .ID_W   (ID_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_c_real   (in_c_real),
        .in_c_imag   (in_c_imag),
        .in_id       (in_id),
        .in_max_iter (in_max_iter),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_id      (out_id),
        .out_iter    (out_iter),
        .out_escaped (out_escaped),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Offer a job, wait (bounded) for it to be accepted, then scramble the inputs.
    task automatic start_job(input logic [31:0] cr, input logic [31:0] ci,
                             input logic [ID_W-1:0] id, input logic [ITER_W-1:0] mx);
        int k;
        @(negedge clk);
        in_c_real   = cr;
        in_c_imag   = ci;
        in_id       = id;
        in_max_iter = mx;
        in_valid    = 1'b1;
        k = 0;
        while (!in_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_c_real   = 32'hDEAD_BEEF;
        in_c_imag   = 32'h1234_5678;
        in_id       = '1;
        in_max_iter = 16'h0007;
    endtask

    // Count negedges after the accept edge until out_valid; lat=budget+ on timeout.
    task automatic wait_result(input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat <= budget);
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1)     begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)    begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (out_id !== '0)         begin n_err++; $display("FAIL reset_out_id: got %h want 0", out_id); end
        n_cmp++; if (out_iter !== '0)       begin n_err++; $display("FAIL reset_out_iter: got %0d want 0", out_iter); end
        n_cmp++; if (out_escaped !== 1'b0)  begin n_err++; $display("FAIL reset_out_escaped: got %b want 0", out_escaped); end
        rst = 1'b0;
    endtask

    task automatic test_origin_limit();
        int lat;
        start_job(32'h0000_0000, 32'h0000_0000, 20'h12345, 16'd256);
        n_cmp++; if (busy !== 1'b1)     begin n_err++; $display("FAIL origin_busy: got %b want 1", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL origin_in_ready: got %b want 0", in_ready); end
        wait_result(400, lat);
        n_cmp++; if (lat != 257)           begin n_err++; $display("FAIL origin_latency: got %0d want 257", lat); end
        n_cmp++; if (out_iter !== 16'd256) begin n_err++; $display("FAIL origin_iter: got %0d want 256", out_iter); end
        n_cmp++; if (out_escaped !== 1'b0) begin n_err++; $display("FAIL origin_escaped: got %b want 0", out_escaped); end
        n_cmp++; if (out_id !== 20'h12345) begin n_err++; $display("FAIL origin_id: got %h want 12345", out_id); end
        take_result();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL origin_release: valid=%b ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_escape_one();
        int lat;
        start_job(32'h3000_0000, 32'h0000_0000, 20'h00001, 16'd256);
        wait_result(400, lat);
        n_cmp++; if (out_valid !== 1'b1)   begin n_err++; $display("FAIL esc1_timeout: out_valid=%b want 1", out_valid); end
        n_cmp++; if (out_iter !== 16'd1)   begin n_err++; $display("FAIL esc1_iter: got %0d want 1", out_iter); end
        n_cmp++; if (out_escaped !== 1'b1) begin n_err++; $display("FAIL esc1_escaped: got %b want 1", out_escaped); end
        n_cmp++; if (out_id !== 20'h00001) begin n_err++; $display("FAIL esc1_id: got %h want 00001", out_id); end
        take_result();
    endtask

    task automatic test_escape_wrap(input logic [ID_W-1:0] id, input string tag);
        int lat;
        start_job(32'h1000_0000, 32'h0000_0000, id, 16'd256);
        wait_result(400, lat);
        n_cmp++; if (out_iter !== 16'd3)   begin n_err++; $display("FAIL %s_iter: got %0d want 3", tag, out_iter); end
        n_cmp++; if (out_escaped !== 1'b1) begin n_err++; $display("FAIL %s_escaped: got %b want 1", tag, out_escaped); end
        n_cmp++; if (out_id !== id)        begin n_err++; $display("FAIL %s_id: got %h want %h", tag, out_id, id); end
        take_result();
    endtask

    task automatic test_bound_equal();
        int lat;
        start_job(32'hE000_0000, 32'h0000_0000, 20'h0BEEF, 16'd100);
        wait_result(400, lat);
        n_cmp++; if (lat != 101)           begin n_err++; $display("FAIL bound_latency: got %0d want 101", lat); end
        n_cmp++; if (out_iter !== 16'd100) begin n_err++; $display("FAIL bound_iter: got %0d want 100", out_iter); end
        n_cmp++; if (out_escaped !== 1'b0) begin n_err++; $display("FAIL bound_escaped: got %b want 0", out_escaped); end
        take_result();
    endtask

    // c = i: orbit 0, i, -1+i, -i, -1+i, ... stays bounded; exercises the imaginary path
    task automatic test_imag_cycle();
        int lat;
        start_job(32'h0000_0000, 32'h1000_0000, 20'h77777, 16'd10);
        wait_result(400, lat);
        n_cmp++; if (lat != 11)            begin n_err++; $display("FAIL imag_latency: got %0d want 11", lat); end
        n_cmp++; if (out_iter !== 16'd10)  begin n_err++; $display("FAIL imag_iter: got %0d want 10", out_iter); end
        n_cmp++; if (out_escaped !== 1'b0) begin n_err++; $display("FAIL imag_escaped: got %b want 0", out_escaped); end
        take_result();
    endtask

    task automatic test_zero_iter();
        int lat;
        start_job(32'h3000_0000, 32'h0000_0000, 20'h00ABC, 16'd0);
        wait_result(20, lat);
        n_cmp++; if (lat != 1)             begin n_err++; $display("FAIL zero_latency: got %0d want 1", lat); end
        n_cmp++; if (out_iter !== 16'd0)   begin n_err++; $display("FAIL zero_iter: got %0d want 0", out_iter); end
        n_cmp++; if (out_escaped !== 1'b0) begin n_err++; $display("FAIL zero_escaped: got %b want 0", out_escaped); end
        n_cmp++; if (out_id !== 20'h00ABC) begin n_err++; $display("FAIL zero_id: got %h want 00abc", out_id); end
        take_result();
    endtask

    // Result held under backpressure while a second job waits with in_valid high;
    // that job is accepted only after the result handshake.
    task automatic test_back_to_back();
        int lat;
        start_job(32'h0000_0000, 32'h0000_0000, 20'h55555, 16'd3);
        wait_result(100, lat);
        in_c_real   = 32'h3000_0000;
        in_c_imag   = 32'h0000_0000;
        in_id       = 20'hABCDE;
        in_max_iter = 16'd256;
        in_valid    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_iter !== 16'd3 ||
                out_escaped !== 1'b0 || out_id !== 20'h55555) begin
                n_err++;
                $display("FAIL hold_cycle%0d: valid=%b ready=%b iter=%0d esc=%b id=%h want 1 0 3 0 55555",
                         i, out_valid, in_ready, out_iter, out_escaped, out_id);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL b2b_accept: ready=%b busy=%b want 0 1", in_ready, busy);
        end
        wait_result(400, lat);
        n_cmp++; if (out_iter !== 16'd1 || out_escaped !== 1'b1 || out_id !== 20'hABCDE) begin
            n_err++; $display("FAIL b2b_result: iter=%0d esc=%b id=%h want 1 1 abcde", out_iter, out_escaped, out_id);
        end
        take_result();
    endtask

    task automatic test_reset_mid_job();
        start_job(32'h0000_0000, 32'h0000_0000, 20'h31415, 16'd256);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL midrst_async: valid=%b ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midrst_no_result: valid=%b busy=%b want 0 0", out_valid, busy);
        end
        test_escape_wrap(20'h27182, "after_rst");
    endtask

    initial begin
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_c_real   = '0;
        in_c_imag   = '0;
        in_id       = '0;
        in_max_iter = '0;
        rst         = 1'b1;
        test_reset();
        test_origin_limit();
        test_escape_one();
        test_escape_wrap(20'h0F00D, "wrap");
        test_bound_equal();
        test_imag_cycle();
        test_zero_iter();
        test_back_to_back();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
